// File: rtl/rfsoc_seq_pkg.sv
// Shared types and default sizing for the RF capture sequencer.
package rfsoc_seq_pkg;

  localparam int unsigned DEF_RST_CYCLES  = 16;
  localparam int unsigned DEF_CNT_W       = 32;
  localparam int unsigned DEF_ITER_W      = 16;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RST       = 3'd1,
    S_DAC_GO    = 3'd2,
    S_LEAD      = 3'd3,
    S_ADC_GO    = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_NEXT      = 3'd6,
    S_FLUSH     = 3'd7
  } seq_state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_DAC   = 2'd1,
    ERR_ADC   = 2'd2,
    ERR_ABORT = 2'd3
  } seq_err_e;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop level synchronizer for single-bit signals from another clock domain.
module bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/rf_capture_sequencer.sv
// Sequences repeated DAC playback / ADC capture iterations with reset, lead delay,
// completion/timeout handling, error and abort flushing, and sticky status.
module rf_capture_sequencer
  import rfsoc_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES  = DEF_RST_CYCLES,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned ITER_W      = DEF_ITER_W,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic              axilite_clk,
  input  logic              axilite_rstb,
  input  logic              seq_start,
  input  logic              seq_abort,
  input  logic [CNT_W-1:0]  cfg_lead,
  input  logic [CNT_W-1:0]  cfg_timeout,
  input  logic [ITER_W-1:0] cfg_iters,
  input  logic              adc_cap_done,
  input  logic              dac_rd_err,
  input  logic              adc_wr_err,
  output logic              dac_reset,
  output logic              dac_start,
  output logic              adc_reset,
  output logic              adc_start,
  output logic              seq_busy,
  output logic              seq_done,
  output logic              seq_err,
  output logic [1:0]        seq_err_code,
  output logic [2:0]        seq_state,
  output logic [ITER_W-1:0] iter_cnt
);

  localparam logic [CNT_W-1:0] RST_LEN = CNT_W'(RST_CYCLES);

  seq_state_e        state_q, state_d;
  seq_err_e          err_code_q, err_code_d, flush_code;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [CNT_W-1:0]  lead_q, timeout_q;
  logic [ITER_W-1:0] iters_q, iter_cnt_q, iter_cnt_d;
  logic              cap_sync, cap_prev, dac_err_sync, adc_err_sync;
  logic              cap_rise, completion, accept, in_run;
  logic              path_rst_q, path_rst_d;
  logic              dac_start_q, dac_start_d, adc_start_q, adc_start_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_cap (
    .clk(axilite_clk), .rst_n(axilite_rstb), .d(adc_cap_done), .q(cap_sync)
  );
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_dac_err (
    .clk(axilite_clk), .rst_n(axilite_rstb), .d(dac_rd_err), .q(dac_err_sync)
  );
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_adc_err (
    .clk(axilite_clk), .rst_n(axilite_rstb), .d(adc_wr_err), .q(adc_err_sync)
  );

  assign accept   = (state_q == S_IDLE) && seq_start;
  assign cap_rise = cap_sync && !cap_prev;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  assign in_run   = (state_q == S_DAC_GO) || (state_q == S_LEAD) ||
                    (state_q == S_ADC_GO) || (state_q == S_WAIT_DONE);

  // State register
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) state_q <= S_IDLE;
    else               state_q <= state_d;
  end

  // Next-state: normal flow, then path errors, then abort as highest priority
  always_comb begin
    state_d    = state_q;
    flush_code = ERR_NONE;
    completion = 1'b0;
    unique case (state_q)
      S_IDLE:      if (seq_start) state_d = S_RST;
      S_RST:       if (cnt_inc == RST_LEN) state_d = S_DAC_GO;
      S_DAC_GO:    state_d = (lead_q == '0) ? S_ADC_GO : S_LEAD;
      S_LEAD:      if (cnt_inc == lead_q) state_d = S_ADC_GO;
      S_ADC_GO:    state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (cap_rise) begin
          state_d    = S_NEXT;
          completion = 1'b1;
        end else if ((timeout_q != '0) && (cnt_inc == timeout_q)) begin
          state_d    = S_FLUSH;
          flush_code = ERR_ADC;
        end
      end
      S_NEXT:      state_d = ((iters_q != '0) && (iter_cnt_q == iters_q)) ? S_IDLE : S_RST;
      S_FLUSH:     if (cnt_inc == RST_LEN) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (in_run && (dac_err_sync || adc_err_sync)) begin
      state_d    = S_FLUSH;
      flush_code = dac_err_sync ? ERR_DAC : ERR_ADC;
      completion = 1'b0;
    end
    if (seq_abort && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
      state_d    = S_FLUSH;
      flush_code = ERR_ABORT;
      completion = 1'b0;
    end
  end

  // Output/datapath next values; outputs are decoded from the next state so they register cleanly
  always_comb begin
    path_rst_d  = (state_d == S_RST) || (state_d == S_FLUSH);
    dac_start_d = (state_d == S_DAC_GO);
    adc_start_d = (state_d == S_ADC_GO);
    busy_d      = (state_d != S_IDLE);
    done_d      = done_q;
    err_d       = err_q;
    err_code_d  = err_code_q;
    iter_cnt_d  = iter_cnt_q;
    cnt_d       = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_inc;
    if (accept) begin
      done_d     = 1'b0;
      err_d      = 1'b0;
      err_code_d = ERR_NONE;
      iter_cnt_d = '0;
    end
    if (completion && ((iters_q == '0) || (iter_cnt_q != '1))) begin
      iter_cnt_d = iter_cnt_q + ITER_W'(1);
    end
    if ((state_q == S_NEXT) && (state_d == S_IDLE)) done_d = 1'b1;
    if ((state_d == S_FLUSH) && (state_q != S_FLUSH)) begin
      err_d      = 1'b1;
      err_code_d = flush_code;
    end
  end

  // Output, counter and shadow-config registers
  always_ff @(posedge axilite_clk or negedge axilite_rstb) begin
    if (!axilite_rstb) begin
      path_rst_q  <= 1'b0;
      dac_start_q <= 1'b0;
      adc_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      iter_cnt_q  <= '0;
      cnt_q       <= '0;
      cap_prev    <= 1'b0;
      lead_q      <= '0;
      timeout_q   <= '0;
      iters_q     <= '0;
    end else begin
      path_rst_q  <= path_rst_d;
      dac_start_q <= dac_start_d;
      adc_start_q <= adc_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      iter_cnt_q  <= iter_cnt_d;
      cnt_q       <= cnt_d;
      cap_prev    <= cap_sync;
      if (accept) begin
        lead_q    <= cfg_lead;
        timeout_q <= cfg_timeout;
        iters_q   <= cfg_iters;
      end
    end
  end

  assign dac_reset    = path_rst_q;
  assign adc_reset    = path_rst_q;
  assign dac_start    = dac_start_q;
  assign adc_start    = adc_start_q;
  assign seq_busy     = busy_q;
  assign seq_done     = done_q;
  assign seq_err      = err_q;
  assign seq_err_code = err_code_q;
  assign seq_state    = state_q;
  assign iter_cnt     = iter_cnt_q;

endmodule

// File: tb/tb_rf_capture_sequencer.sv
// Randomized self-checking bench: event timestamps from the DUT are compared with
// cycle arithmetic derived from the sequencing rules.
`timescale 1ns/1ps
module tb_rf_capture_sequencer;

  localparam int unsigned RST_N  = 16;
  localparam int unsigned CNT_W  = 32;
  localparam int unsigned ITER_W = 16;
  localparam int unsigned SYNC   = 2;
  localparam int          SYNC_LAT = SYNC + 1;

  logic              clk = 1'b0;
  logic              axilite_rstb = 1'b0;
  logic              seq_start = 1'b0, seq_abort = 1'b0;
  logic [CNT_W-1:0]  cfg_lead = '0, cfg_timeout = '0;
  logic [ITER_W-1:0] cfg_iters = '0;
  logic              adc_cap_done = 1'b0, dac_rd_err = 1'b0, adc_wr_err = 1'b0;
  logic              dac_reset, dac_start, adc_reset, adc_start;
  logic              seq_busy, seq_done, seq_err;
  logic [1:0]        seq_err_code;
  logic [2:0]        seq_state;
  logic [ITER_W-1:0] iter_cnt;

  rf_capture_sequencer #(
    .RST_CYCLES(RST_N), .CNT_W(CNT_W), .ITER_W(ITER_W), .SYNC_STAGES(SYNC)
  ) dut (
    .axilite_clk(clk), .axilite_rstb(axilite_rstb),
    .seq_start(seq_start), .seq_abort(seq_abort),
    .cfg_lead(cfg_lead), .cfg_timeout(cfg_timeout), .cfg_iters(cfg_iters),
    .adc_cap_done(adc_cap_done), .dac_rd_err(dac_rd_err), .adc_wr_err(adc_wr_err),
    .dac_reset(dac_reset), .dac_start(dac_start), .adc_reset(adc_reset), .adc_start(adc_start),
    .seq_busy(seq_busy), .seq_done(seq_done), .seq_err(seq_err), .seq_err_code(seq_err_code),
    .seq_state(seq_state), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event log filled from DUT outputs once per cycle
  int dac_q[$], adc_q[$], rise_q[$], len_q[$];
  int busy_fall = -1, rise_at = 0;
  bit prev_rst = 0, prev_busy = 0, rst_split = 0;

  initial forever begin
    @(negedge clk);
    if (!axilite_rstb) begin
      prev_rst  = 0;
      prev_busy = 0;
    end else begin
      if (dac_start) dac_q.push_back(cyc);
      if (adc_start) adc_q.push_back(cyc);
      if (dac_reset && !prev_rst) begin rise_q.push_back(cyc); rise_at = cyc; end
      if (!dac_reset && prev_rst) len_q.push_back(cyc - rise_at);
      if (dac_reset != adc_reset) rst_split = 1;
      if (prev_busy && !seq_busy) busy_fall = cyc;
      prev_rst  = dac_reset;
      prev_busy = seq_busy;
    end
  end

  // Capture-path model: cap_done rises cap_delay cycles after each adc_start, held 4 cycles
  bit cap_en = 0;
  int cap_delay = 0, cap_at = -100;

  initial forever begin
    @(negedge clk);
    if (!axilite_rstb) begin
      adc_cap_done = 1'b0;
      cap_at = -100;
    end else begin
      if (adc_start && cap_en) cap_at = cyc + cap_delay;
      if (cyc == cap_at) adc_cap_done = 1'b1;
      else if (cyc == cap_at + 4) adc_cap_done = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int s_cyc;

  function automatic logic [63:0] outs_vec();
    return 64'({dac_reset, dac_start, adc_reset, adc_start, seq_busy, seq_done, seq_err,
                seq_err_code, seq_state, iter_cnt});
  endfunction

  task automatic clear_log();
    dac_q.delete(); adc_q.delete(); rise_q.delete(); len_q.delete();
    busy_fall = -1;
    rst_split = 0;
  endtask

  task automatic start_run(input int l, input int t, input int n);
    clear_log();
    @(negedge clk);
    cfg_lead    = CNT_W'(l);
    cfg_timeout = CNT_W'(t);
    cfg_iters   = ITER_W'(n);
    seq_start   = 1'b1;
    s_cyc       = cyc + 1;
    @(negedge clk);
    seq_start   = 1'b0;
    cfg_lead    = CNT_W'($urandom);
    cfg_timeout = CNT_W'($urandom);
    cfg_iters   = ITER_W'($urandom);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!seq_busy) begin ok = 1; break; end
    end
    check({tag, "_idle"}, 64'(ok), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic wait_events(input bit is_adc, input int n, input int budget, input string tag);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((is_adc ? adc_q.size() : dac_q.size()) >= n) begin ok = 1; break; end
    end
    check({tag, "_reach"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_neg(input int target);
    @(negedge clk);
    while (cyc < target) @(negedge clk);
  endtask

  // Expected timeline for a run that completes all n iterations
  task automatic check_normal(input string tag, input int n, input int l, input int d);
    int period;
    period = (l + 1) + (d + SYNC_LAT) + 1 + RST_N;
    check({tag, "_ndac"}, 64'(dac_q.size()), 64'(n));
    check({tag, "_nadc"}, 64'(adc_q.size()), 64'(n));
    check({tag, "_rst0"}, 64'(rise_q.size() > 0 ? rise_q[0] : -1), 64'(s_cyc));
    for (int i = 0; i < n && i < dac_q.size(); i++) begin
      check({tag, "_dac_t"}, 64'(dac_q[i]), 64'(s_cyc + RST_N + i * period));
      if (i < adc_q.size()) check({tag, "_lead"}, 64'(adc_q[i] - dac_q[i]), 64'(l + 1));
    end
    foreach (len_q[i]) check({tag, "_rstlen"}, 64'(len_q[i]), 64'(RST_N));
    if (adc_q.size() > 0)
      check({tag, "_busyfall"}, 64'(busy_fall), 64'(adc_q[adc_q.size()-1] + d + SYNC_LAT + 1));
    check({tag, "_done"}, 64'(seq_done), 64'd1);
    check({tag, "_err"}, 64'(seq_err), 64'd0);
    check({tag, "_code"}, 64'(seq_err_code), 64'd0);
    check({tag, "_iter"}, 64'(iter_cnt), 64'(n));
    check({tag, "_split"}, 64'(rst_split), 64'd0);
  endtask

  task automatic check_flush(input string tag, input int code, input int iters, input int rise);
    check({tag, "_err"}, 64'(seq_err), 64'd1);
    check({tag, "_done"}, 64'(seq_done), 64'd0);
    check({tag, "_code"}, 64'(seq_err_code), 64'(code));
    check({tag, "_iter"}, 64'(iter_cnt), 64'(iters));
    check({tag, "_rise"}, 64'(rise_q.size() > 0 ? rise_q[rise_q.size()-1] : -1), 64'(rise));
    check({tag, "_len"}, 64'(len_q.size() > 0 ? len_q[len_q.size()-1] : -1), 64'(RST_N));
    check({tag, "_busyfall"}, 64'(busy_fall), 64'(rise + RST_N));
  endtask

  initial begin
    int n, l, d, t, e, a;
    repeat (3) @(negedge clk);
    check("reset_outs", outs_vec(), 64'd0);
    axilite_rstb = 1'b1;

    // Single iteration, lead 10, capture 50 cycles later
    cap_en = 1; cap_delay = 50;
    start_run(10, 0, 1);
    wait_idle(400, "t1");
    check_normal("t1", 1, 10, 50);
    check("t1_busy", 64'(seq_busy), 64'd0);

    // Three iterations with zero lead
    cap_delay = $urandom_range(0, 15);
    start_run(0, 0, 3);
    wait_idle(400, "t2");
    check_normal("t2", 3, 0, cap_delay);

    // Randomized completing runs, timeout either off or safely beyond completion
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 3);
      l = $urandom_range(0, 12);
      d = $urandom_range(0, 20);
      t = ($urandom_range(0, 1) == 0) ? 0 : d + SYNC_LAT + $urandom_range(0, 30);
      cap_delay = d;
      start_run(l, t, n);
      wait_idle(n * (l + d + 40) + 50, "rnd");
      check_normal("rnd", n, l, d);
    end

    // Timeout with capture never completing
    cap_en = 0;
    l = $urandom_range(0, 8);
    start_run(l, 100, 1);
    wait_idle(400, "tmo");
    a = (adc_q.size() > 0) ? adc_q[0] : 0;
    check("tmo_nadc", 64'(adc_q.size()), 64'd1);
    check_flush("tmo", 2, 0, a + 100 + 1);

    // Small random timeout
    t = $urandom_range(1, 6);
    start_run(2, t, 1);
    wait_idle(200, "tmo2");
    a = (adc_q.size() > 0) ? adc_q[0] : 0;
    check_flush("tmo2", 2, 0, a + t + 1);

    // dac read error during LEAD
    start_run(20, 0, 1);
    wait_events(0, 1, 100, "derr");
    @(negedge clk); e = cyc; dac_rd_err = 1'b1;
    wait_idle(200, "derr");
    dac_rd_err = 1'b0;
    check("derr_nadc", 64'(adc_q.size()), 64'd0);
    check_flush("derr", 1, 0, e + SYNC_LAT);
    repeat (4) @(negedge clk);

    // adc write error during WAIT_DONE
    start_run(3, 0, 1);
    wait_events(1, 1, 100, "aerr");
    @(negedge clk); e = cyc; adc_wr_err = 1'b1;
    wait_idle(200, "aerr");
    adc_wr_err = 1'b0;
    check_flush("aerr", 2, 0, e + SYNC_LAT);
    repeat (4) @(negedge clk);

    // Both errors at once: dac reported
    start_run(3, 0, 1);
    wait_events(1, 1, 100, "berr");
    @(negedge clk); e = cyc; adc_wr_err = 1'b1; dac_rd_err = 1'b1;
    wait_idle(200, "berr");
    adc_wr_err = 1'b0; dac_rd_err = 1'b0;
    check_flush("berr", 1, 0, e + SYNC_LAT);
    repeat (4) @(negedge clk);

    // Abort during LEAD, repeated abort in FLUSH, abort in IDLE
    start_run(15, 0, 2);
    wait_events(0, 1, 100, "abl");
    @(negedge clk); e = cyc; seq_abort = 1'b1;
    @(negedge clk); seq_abort = 1'b0;
    repeat (3) @(negedge clk);
    seq_abort = 1'b1;
    @(negedge clk); seq_abort = 1'b0;
    wait_idle(100, "abl");
    check("abl_nadc", 64'(adc_q.size()), 64'd0);
    check_flush("abl", 3, 0, e + 1);
    @(negedge clk); seq_abort = 1'b1;
    @(negedge clk); seq_abort = 1'b0;
    @(posedge clk); #1;
    check("abidle_busy", 64'(seq_busy), 64'd0);
    check("abidle_code", 64'(seq_err_code), 64'd3);

    // Continuous mode: abort lands on the 6th completion edge
    cap_en = 1;
    d = $urandom_range(0, 10);
    l = $urandom_range(0, 6);
    cap_delay = d;
    start_run(l, 0, 0);
    wait_events(1, 6, 1000, "abc");
    a = (adc_q.size() >= 6) ? adc_q[5] : 0;
    wait_neg(a + d + SYNC);
    seq_abort = 1'b1;
    @(negedge clk); seq_abort = 1'b0;
    wait_idle(100, "abc");
    check("abc_ndac", 64'(dac_q.size()), 64'd6);
    check_flush("abc", 3, 5, a + d + SYNC_LAT);

    // Async reset in WAIT_DONE after two completions
    cap_delay = 5;
    start_run(2, 0, 0);
    wait_events(1, 3, 500, "arst");
    @(negedge clk);
    check("arst_state", 64'(seq_state), 64'd5);
    check("arst_iter", 64'(iter_cnt), 64'd2);
    axilite_rstb = 1'b0;
    #1;
    check("arst_outs", outs_vec(), 64'd0);
    @(negedge clk); axilite_rstb = 1'b1;

    // Start while busy is ignored and its cfg is not latched
    cap_delay = 4;
    start_run(5, 0, 1);
    repeat (3) @(negedge clk);
    cfg_lead = CNT_W'(15); cfg_iters = ITER_W'(3); cfg_timeout = CNT_W'(2);
    seq_start = 1'b1;
    @(negedge clk); seq_start = 1'b0;
    wait_idle(200, "busy");
    check_normal("busy", 1, 5, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
